// File: rtl/rca_result_checker.sv
// Result checker for a WIDTH-bit ripple-carry adder: recomputes the golden sum,
// compares it with the adder response one cycle later and keeps run statistics.
module rca_result_checker #(
  parameter int WIDTH = 4,
  parameter int NVEC  = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             cin,
  input  logic [WIDTH-1:0] o,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH:0]   fail_exp,
  output logic [WIDTH:0]   fail_got
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] NVEC_C   = CNT_W'(NVEC);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NVEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;
  logic             pipe_valid;
  logic [WIDTH:0]   pipe_exp;
  logic [WIDTH:0]   pipe_got;
  logic [CNT_W-1:0] pipe_idx;

  logic [WIDTH:0]   golden;
  logic             take;
  logic             mismatch;

  assign golden    = {1'b0, i0} + {1'b0, i1} + {{WIDTH{1'b0}}, cin};
  assign vec_ready = (state == RUN) && (acc_cnt < NVEC_C);
  assign take      = vec_valid && vec_ready;
  assign mismatch  = (pipe_exp != pipe_got);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == {CNT_W{1'b0}});

  // Run control, capture stage and compare/statistics stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc_cnt    <= {CNT_W{1'b0}};
      pipe_valid <= 1'b0;
      pipe_exp   <= {(WIDTH+1){1'b0}};
      pipe_got   <= {(WIDTH+1){1'b0}};
      pipe_idx   <= {CNT_W{1'b0}};
      vec_cnt    <= {CNT_W{1'b0}};
      err_cnt    <= {CNT_W{1'b0}};
      fail_valid <= 1'b0;
      fail_idx   <= {CNT_W{1'b0}};
      fail_exp   <= {(WIDTH+1){1'b0}};
      fail_got   <= {(WIDTH+1){1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            acc_cnt    <= {CNT_W{1'b0}};
            pipe_valid <= 1'b0;
            pipe_exp   <= {(WIDTH+1){1'b0}};
            pipe_got   <= {(WIDTH+1){1'b0}};
            pipe_idx   <= {CNT_W{1'b0}};
            vec_cnt    <= {CNT_W{1'b0}};
            err_cnt    <= {CNT_W{1'b0}};
            fail_valid <= 1'b0;
            fail_idx   <= {CNT_W{1'b0}};
            fail_exp   <= {(WIDTH+1){1'b0}};
            fail_got   <= {(WIDTH+1){1'b0}};
          end else begin
            state <= state;
          end
        end
        RUN: begin
          if (take) begin
            pipe_valid <= 1'b1;
            pipe_exp   <= golden;
            pipe_got   <= {cout, o};
            pipe_idx   <= acc_cnt;
            acc_cnt    <= acc_cnt + CNT_ONE;
          end else begin
            pipe_valid <= 1'b0;
          end
          // The index travels with the tuple, so the final commit is what ends the run
          if (pipe_valid) begin
            vec_cnt <= vec_cnt + CNT_ONE;
            if (mismatch) begin
              if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
              end else begin
                err_cnt <= err_cnt;
              end
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_idx   <= pipe_idx;
                fail_exp   <= pipe_exp;
                fail_got   <= pipe_got;
              end else begin
                fail_valid <= fail_valid;
              end
            end else begin
              err_cnt <= err_cnt;
            end
            if (pipe_idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state      <= IDLE;
          pipe_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_result_checker.sv
// Directed, table-driven bench for rca_result_checker: hand-computed sums plus
// hand-written fault responses, applied under several gap/fault/reset scenarios.
module tb_rca_result_checker;

  localparam int WIDTH = 4;
  localparam int NVEC  = 9;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, start, vec_valid, vec_ready;
  logic [WIDTH-1:0] i0, i1, o;
  logic             cin, cout;
  logic             busy, done, pass, fail_valid;
  logic [CNT_W-1:0] vec_cnt, err_cnt, fail_idx;
  logic [WIDTH:0]   fail_exp, fail_got;

  always #5 clk = ~clk;

  rca_result_checker #(.WIDTH(WIDTH), .NVEC(NVEC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .i0(i0), .i1(i1), .cin(cin), .o(o), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_exp(fail_exp),
    .fail_got(fail_got)
  );

  typedef struct {
    logic [3:0] i0;
    logic [3:0] i1;
    logic       cin;
    logic [4:0] sum;  // hand-computed golden {carry, sum}
    logic [4:0] bad;  // faulty response used when the vector is corrupted
  } vec_t;

  vec_t tbl [NVEC];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_ready"}, vec_ready, 0);
    check({tag, "_vec_cnt"}, vec_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_valid"}, fail_valid, 0);
    check({tag, "_fail_idx"}, fail_idx, 0);
    check({tag, "_fail_exp"}, fail_exp, 0);
    check({tag, "_fail_got"}, fail_got, 0);
  endtask

  task automatic drive_vec(input int i, input bit bad);
    i0  = tbl[i].i0;
    i1  = tbl[i].i1;
    cin = tbl[i].cin;
    {cout, o} = bad ? tbl[i].bad : tbl[i].sum;
    vec_valid = 1'b1;
  endtask

  // Full run: start pulse, NVEC vectors with `gap` idle cycles before each.
  task automatic run(input logic [NVEC-1:0] mask, input int gap, input bit extra, input bit mid_start);
    int e;
    int exp_err;
    int first;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_vec_cnt", vec_cnt, 0);
    check("start_err_cnt", err_cnt, 0);
    check("start_fail_valid", fail_valid, 0);
    for (int i = 0; i < NVEC; i++) begin
      for (int g = 0; g < gap; g++) begin
        vec_valid = 1'b0;
        tick();
        e++;
      end
      check("ready_in_run", vec_ready, 1);
      drive_vec(i, mask[i]);
      start = mid_start && (i == 4);
      tick();
      e++;
      start = 1'b0;
      check("latency_vec_cnt", vec_cnt, i);
    end
    vec_valid = extra;
    check("ready_low_after_last", vec_ready, 0);
    check("done_not_early", done, 0);
    tick();
    e++;
    check("done_edge", e, NVEC + 1 + NVEC * gap);
    check("done", done, 1);
    check("busy_low", busy, 0);
    check("final_vec_cnt", vec_cnt, NVEC);
    if (extra) begin
      for (int k = 0; k < 3; k++) begin
        drive_vec(k, 1'b1);
        tick();
        check("extra_ready", vec_ready, 0);
        check("extra_vec_cnt", vec_cnt, NVEC);
      end
    end
    vec_valid = 1'b0;
    exp_err = 0;
    first = -1;
    for (int i = 0; i < NVEC; i++) begin
      if (mask[i]) begin
        exp_err++;
        if (first < 0) first = i;
      end
    end
    check("final_err_cnt", err_cnt, exp_err);
    check("final_pass", pass, (exp_err == 0));
    check("final_fail_valid", fail_valid, (exp_err != 0));
    if (first >= 0) begin
      check("fail_idx", fail_idx, first);
      check("fail_exp", fail_exp, tbl[first].sum);
      check("fail_got", fail_got, tbl[first].bad);
    end
  endtask

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 1'b0, 5'b00000, 5'b00001};
    tbl[1] = '{4'b0011, 4'b0101, 1'b0, 5'b01000, 5'b11000};
    tbl[2] = '{4'b1010, 4'b0101, 1'b1, 5'b10000, 5'b00000};
    tbl[3] = '{4'b0111, 4'b0001, 1'b0, 5'b01000, 5'b00111};
    tbl[4] = '{4'b1111, 4'b0001, 1'b1, 5'b10001, 5'b00001};
    tbl[5] = '{4'b1001, 4'b1001, 1'b0, 5'b10010, 5'b10011};
    tbl[6] = '{4'b0001, 4'b0010, 1'b1, 5'b00100, 5'b00101};
    tbl[7] = '{4'b1100, 4'b0011, 1'b0, 5'b01111, 5'b01110};
    tbl[8] = '{4'b1111, 4'b1111, 1'b1, 5'b11111, 5'b01111};

    // Reset together with start: reset wins
    reset = 1'b0; start = 1'b1; vec_valid = 1'b0;
    i0 = 4'd0; i1 = 4'd0; cin = 1'b0; o = 4'd0; cout = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("idle_after_reset", busy, 0);

    run(9'h000, 0, 1'b0, 1'b0);   // clean back-to-back run
    run(9'h008, 0, 1'b0, 1'b1);   // vector 3 fault, start ignored mid-run, start from DONE
    run(9'h0A4, 0, 1'b0, 1'b0);   // faults on 2, 5, 7
    run(9'h100, 0, 1'b0, 1'b0);   // full-scale vector with cout dropped
    run(9'h000, 2, 1'b1, 1'b0);   // bubbles and surplus tuples

    // Reset in the middle of a run with one fault already captured
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_vec(i, (i == 2));
      tick();
    end
    check("mid_err_cnt", err_cnt, 1);
    check("mid_fail_valid", fail_valid, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_all_zero("mid_reset");
    tick();
    check("post_reset_vec_cnt", vec_cnt, 0);
    check("post_reset_busy", busy, 0);
    vec_valid = 1'b0;

    run(9'h000, 0, 1'b0, 1'b0);   // fresh run from IDLE after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rca_result_checker.md
# rca_result_checker

Synthesizable self-checking monitor for the 4-bit ripple-carry adder datapath. It consumes each operand vector `{i0, i1, cin}` applied to the adder together with the adder's response `{o, cout}`. It computes the golden sum, compares it against the response, and keeps pass/error statistics. It also captures the first mismatch. It sits on the receiving side of the adder-vector interface, opposite the stimulus driver, and reports a run-level verdict once a programmed number of vectors has been checked.

## Interface
Parameters:
- `WIDTH`, default 4: operand width; golden and observed sums are `WIDTH+1` bits.
- `NVEC`, default 9: number of vectors per run; must be at least 1 and at most 2^`CNT_W`−1.
- `CNT_W`, default 8: width of the counters and of the index fields.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `start`  in  1  one-cycle pulse that begins a run.
- `vec_valid`  in  1  the operand/response tuple is present this cycle.
- `vec_ready`  out  1  the checker accepts a tuple this cycle.
- `i0`, `i1`  in  `WIDTH`  operands applied to the adder.
- `cin`  in  1  carry-in applied to the adder.
- `o`  in  `WIDTH`  sum returned by the adder.
- `cout`  in  1  carry-out returned by the adder.
- `busy`  out  1  a run is in progress.
- `done`  out  1  all `NVEC` vectors of the run have been compared.
- `pass`  out  1  `done` is high and `err_cnt` is 0.
- `vec_cnt`  out  `CNT_W`  number of vectors compared in this run.
- `err_cnt`  out  `CNT_W`  number of mismatching vectors; saturates at all-ones.
- `fail_valid`  out  1  sticky; a mismatch has been captured.
- `fail_idx`  out  `CNT_W`  0-based index of the first failing vector.
- `fail_exp`  out  `WIDTH+1`  golden `{carry, sum}` of the first failing vector.
- `fail_got`  out  `WIDTH+1`  observed `{cout, o}` of the first failing vector.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE on the edge at which the compare of vector `NVEC`−1 is committed.
  - DONE → RUN on `start`.
- `start` handling:
  - In IDLE or DONE, `start` clears every counter, the `fail_*` fields and the pipeline, then enters RUN.
  - In RUN, `start` is ignored.
- Transfer: a tuple is taken when `vec_valid && vec_ready` at a rising edge.
- `vec_ready`: high only in RUN while the internal accepted count is below `NVEC`.
  - It is a combinational function of registered state and does not depend on `vec_valid`.
- Stage 1 (capture edge):
  - Register the golden value `{1'b0,i0} + {1'b0,i1} + cin`, full `WIDTH+1` bits, no truncation.
  - Register the observed value `{cout, o}`.
  - Register the accepted index, equal to the accepted count before increment.
- Stage 2 (next edge):
  - Compare golden and observed over all `WIDTH+1` bits; increment `vec_cnt`.
  - On a mismatch, increment `err_cnt`; `err_cnt` saturates at all-ones.
  - On a mismatch while `fail_valid` is 0, load `fail_idx`, `fail_exp` and `fail_got`, and set `fail_valid`.
  - Once `fail_valid` is set, later mismatches never overwrite the `fail_*` fields.
- `busy` = (state == RUN). `done` = (state == DONE). `pass` = `done` && (`err_cnt` == 0).
- Inputs presented while `vec_ready` is low are dropped and have no effect.
- A stalled producer (`vec_valid` low) simply inserts bubbles; there is no timeout.

## Timing
- Reset values, applied on the first edge with `reset` low:
  - State is IDLE; every output is 0; the pipeline-valid bit is 0.
  - This holds in every state, including mid-RUN; in-flight tuples are discarded and no compare is committed.
- Latency: a tuple accepted at edge T is reflected in `vec_cnt`, `err_cnt` and `fail_*` at edge T+1.
- Throughput: one vector per cycle when `vec_valid` is held high.
- Last vector accepted at edge T:
  - `vec_ready` is low from T onward.
  - `done` and the final counters become visible together at T+1.
  - `busy` falls at T+1.
- A run of `NVEC` back-to-back vectors started by `start` at edge S:
  - First acceptance at S+1.
  - `done` at S+`NVEC`+1.
- `start` and `reset` low in the same cycle: reset wins.
- `start` on the same edge as the last compare commit: the commit completes and the FSM enters DONE; `start` must be reissued from DONE.

## Test plan
- Correct adder model, 9 back-to-back vectors including 0000+0000+0, 0111+0001+0 → 01000, and 1111+0001+1 → 10001:
  - `done` at S+10, `pass`=1, `vec_cnt`=9, `err_cnt`=0, `fail_valid`=0.
- Fault injected on vector 3 (i0=0111, i1=0001, cin=0, o forced to 0111, cout=0):
  - `err_cnt`=1, `fail_idx`=3, `fail_exp`=5'b01000, `fail_got`=5'b00111, `pass`=0.
- Faults on vectors 2, 5 and 7:
  - `err_cnt`=3, and the `fail_*` fields hold vector 2 only.
- Full-scale input 1111+1111+1:
  - Golden value 5'b11111; a response with `cout`=0 is flagged as a mismatch.
- Two idle cycles between each `vec_valid`, plus extra tuples offered after the 9th:
  - `vec_cnt` stops at 9; `vec_ready` stays 0 after the 9th acceptance.
- Behaviour around reset and `start`:
  - `reset` low after 4 vectors: all outputs 0 next edge.
  - `start` issued in RUN: no effect.
  - `start` from DONE: counters clear and a new 9-vector run is accepted.
